// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with single-word fills
//
// Ports:
//   CLK, RST         clock; asynchronous active-high reset
//   imemREN          fetch request from datapath
//   imemaddr         fetch byte address (bits [1:0] ignored)
//   ihit, imemload   hit indication and instruction word (valid same cycle)
//   flush            invalidate every frame, abandon any fill in progress
//   iREN, iaddr      fill request/word address to memory controller
//   iload, iwait     fill data; iwait low marks iload valid
//   miss_count       saturating count of completed fills
`timescale 1ns/1ps

module icache_direct #(
    parameter int FRAMES = 16,
    parameter int IDXW   = 4,
    parameter int CNTW   = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            imemREN,
    input  logic [31:0]     imemaddr,
    output logic            ihit,
    output logic [31:0]     imemload,
    input  logic            flush,
    output logic            iREN,
    output logic [31:0]     iaddr,
    input  logic [31:0]     iload,
    input  logic            iwait,
    output logic [CNTW-1:0] miss_count
);

    localparam int TAGW = 30 - IDXW;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state;
    logic [FRAMES-1:0] valid;
    logic [TAGW-1:0]   tags [FRAMES];
    logic [31:0]       data [FRAMES];

    // Word address of the outstanding miss; the fill works from this copy so
    // the datapath may change imemaddr freely while the fill is in flight.
    logic [29:0]       miss_word;

    logic [TAGW-1:0]   req_tag;
    logic [IDXW-1:0]   req_idx;
    logic [TAGW-1:0]   fill_tag;
    logic [IDXW-1:0]   fill_idx;
    logic              hit;
    logic              fill_done;
    logic              unused_offset;

    assign req_tag  = imemaddr[31:IDXW+2];
    assign req_idx  = imemaddr[IDXW+1:2];
    assign fill_tag = miss_word[29:IDXW];
    assign fill_idx = miss_word[IDXW-1:0];

    // Byte offset within the word has no meaning for a word-wide cache.
    assign unused_offset = &{1'b0, imemaddr[1:0]};

    assign hit = (state == IDLE) && imemREN && valid[req_idx]
                 && (tags[req_idx] == req_tag);

    // flush suppresses the hit so a fetch never sees a frame that is being
    // invalidated on this very edge.
    assign ihit     = hit && !flush;
    assign imemload = ihit ? data[req_idx] : 32'h0;

    // Fill request depends on state only, keeping iwait out of any
    // combinational path back into the memory controller.
    assign iREN  = (state == FILL);
    assign iaddr = {miss_word, 2'b00};

    // A fill that coincides with flush is discarded entirely.
    assign fill_done = (state == FILL) && !iwait && !flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_word  <= '0;
            miss_count <= '0;
        end else if (flush) begin
            state <= IDLE;
            valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_word <= imemaddr[31:2];
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        valid[fill_idx] <= 1'b1;
                        if (miss_count != {CNTW{1'b1}}) begin
                            miss_count <= miss_count + CNTW'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - randomized and directed bench for icache_direct against a frame-level model
`timescale 1ns/1ps

module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        iwait = 1'b1;

    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
    logic [15:0] miss_count;

    logic        s_ihit, s_iREN;
    logic [31:0] s_imemload, s_iaddr;
    logic [1:0]  s_miss_count;

    icache_direct dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iload(iload), .iwait(iwait), .miss_count(miss_count)
    );

    icache_direct #(.CNTW(2)) dut_sat (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(s_ihit), .imemload(s_imemload), .flush(flush), .iREN(s_iREN),
        .iaddr(s_iaddr), .iload(iload), .iwait(iwait), .miss_count(s_miss_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each of the 16 frames remembers which word address it holds.
    bit          mv [16];
    logic [29:0] mw [16];
    logic [31:0] md [16];
    bit          mfill;
    logic [29:0] maddr;
    int          mcnt;

    always @(posedge CLK or posedge RST) begin
        int  ix;
        int  fx;
        bit  h;
        if (RST) begin
            for (int i = 0; i < 16; i++) mv[i] = 1'b0;
            mfill = 1'b0;
            maddr = '0;
            mcnt  = 0;
        end else begin
            ix = int'(imemaddr[5:2]);
            h  = !mfill && imemREN && mv[ix] && (mw[ix] == imemaddr[31:2]);
            if (flush) begin
                for (int i = 0; i < 16; i++) mv[i] = 1'b0;
                mfill = 1'b0;
            end else if (mfill) begin
                if (!iwait) begin
                    fx     = int'(maddr[3:0]);
                    mv[fx] = 1'b1;
                    mw[fx] = maddr;
                    md[fx] = iload;
                    if (mcnt < 65535) mcnt++;
                    mfill = 1'b0;
                end
            end else if (imemREN && !h) begin
                maddr = imemaddr[31:2];
                mfill = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        int   cx;
        bit   eh;
        int   sat;
        cx  = int'(imemaddr[5:2]);
        eh  = !RST && !mfill && imemREN && !flush && mv[cx] && (mw[cx] == imemaddr[31:2]);
        sat = (mcnt > 3) ? 3 : mcnt;
        chk("ihit", ihit, eh);
        chk("imemload", imemload, eh ? md[cx] : 32'h0);
        chk("iREN", iREN, mfill);
        if (mfill) chk("iaddr", iaddr, {maddr, 2'b00});
        chk("miss_count", miss_count, 32'(mcnt));
        chk("sat_ihit", s_ihit, eh);
        chk("sat_count", s_miss_count, 32'(sat));
    end

    task automatic cyc(input bit ren, input logic [31:0] a, input bit fl,
                       input bit wt, input logic [31:0] ld);
        @(posedge CLK);
        #1;
        imemREN  = ren;
        imemaddr = a;
        flush    = fl;
        iwait    = wt;
        iload    = ld;
        @(negedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        #12;
        chk("rst_ihit", ihit, 0);
        chk("rst_iREN", iREN, 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_imemload", imemload, 0);
        chk("rst_count", miss_count, 0);
        #10 RST = 1'b0;

        // Cold miss, three FILL cycles, then hit.
        cyc(1, 32'h40, 0, 1, 0);          chk("cold_miss", ihit, 0);
        cyc(1, 32'h40, 0, 1, 0);          chk("fill1_iren", iREN, 1); chk("fill1_iaddr", iaddr, 32'h40);
        cyc(1, 32'h40, 0, 1, 0);          chk("fill2_iren", iREN, 1);
        cyc(1, 32'h40, 0, 0, 32'h2001_0005); chk("fill3_iren", iREN, 1); chk("fill3_iaddr", iaddr, 32'h40);
        cyc(1, 32'h40, 0, 1, 0);          chk("cold_hit", ihit, 1); chk("cold_load", imemload, 32'h2001_0005);
        chk("cold_count", miss_count, 1); chk("cold_iren", iREN, 0);
        cyc(1, 32'h42, 0, 1, 0);          chk("rep_hit", ihit, 1); chk("rep_load", imemload, 32'h2001_0005);
        chk("rep_iren", iREN, 0);

        // Conflict eviction on index 1.
        cyc(1, 32'h04, 0, 1, 0);
        cyc(1, 32'h04, 0, 0, 32'h1111_1111);
        cyc(1, 32'h44, 0, 1, 0);          chk("conf_miss", ihit, 0); chk("conf_count", miss_count, 2);
        cyc(1, 32'h44, 0, 0, 32'hDEAD_BEEF); chk("conf_iaddr", iaddr, 32'h44);
        cyc(1, 32'h44, 0, 1, 0);          chk("conf_hit", imemload, 32'hDEAD_BEEF); chk("conf_count3", miss_count, 3);
        cyc(1, 32'h04, 0, 1, 0);          chk("evicted_miss", ihit, 0);
        cyc(0, 32'h0, 0, 0, 32'h1111_1111);
        cyc(0, 32'h0, 0, 1, 0);           chk("conf_count4", miss_count, 4);

        // Request address changes while the fill is outstanding.
        cyc(1, 32'h100, 0, 1, 0);
        cyc(1, 32'h200, 0, 1, 0);         chk("mid_iaddr1", iaddr, 32'h100);
        cyc(1, 32'h200, 0, 0, 32'h55);    chk("mid_iaddr2", iaddr, 32'h100);
        cyc(1, 32'h200, 0, 1, 0);         chk("mid_next_miss", ihit, 0); chk("mid_count", miss_count, 5);
        cyc(1, 32'h200, 0, 0, 32'h66);    chk("mid_iaddr3", iaddr, 32'h200);
        cyc(1, 32'h200, 0, 1, 0);         chk("mid_hit", imemload, 32'h66);

        // Flush with several valid frames.
        cyc(0, 32'h0, 1, 1, 0);
        cyc(1, 32'h04, 0, 1, 0);          chk("flush_miss04", ihit, 0);
        cyc(1, 32'h04, 0, 0, 32'h77);
        cyc(1, 32'h200, 0, 1, 0);         chk("flush_miss200", ihit, 0);
        cyc(0, 32'h0, 0, 0, 32'h88);
        cyc(0, 32'h0, 0, 1, 0);           chk("flush_count", miss_count, 8);

        // Flush on the same edge the fill data arrives.
        cyc(1, 32'h300, 0, 1, 0);
        cyc(1, 32'h300, 1, 0, 32'h99);    chk("flushb_iren", iREN, 1);
        cyc(0, 32'h0, 0, 1, 0);           chk("flushb_idle", iREN, 0); chk("flushb_count", miss_count, 8);
        cyc(1, 32'h300, 0, 1, 0);         chk("flushb_miss", ihit, 0);
        cyc(0, 32'h0, 0, 0, 32'h99);
        cyc(0, 32'h0, 0, 1, 0);           chk("sat_hold", s_miss_count, 3);

        // Asynchronous reset while filling.
        cyc(1, 32'h80, 0, 1, 0);
        cyc(1, 32'h80, 0, 1, 0);          chk("arst_pre_iren", iREN, 1);
        #2 RST = 1'b1;
        #1;
        chk("arst_iren", iREN, 0);
        chk("arst_count", miss_count, 0);
        chk("arst_sat_count", s_miss_count, 0);
        @(posedge CLK);
        #2 RST = 1'b0;
        cyc(1, 32'h04, 0, 1, 0);          chk("arst_miss", ihit, 0);
        cyc(0, 32'h0, 0, 0, 32'h1);

        // Randomized traffic over a small address pool so hits, conflicts and
        // flushes all occur frequently.
        for (int n = 0; n < 3000; n++) begin
            ra = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h8000_0000;
            cyc(($urandom_range(0, 9) < 8), ra, ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 1) == 1), $urandom);
        end

        @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
